// File: rtl/gf180mcu_osu_sc_gp12t3v3__rx_sync_filt.sv
// Receive-side synchroniser and glitch filter for an asynchronous level input.
// Produces a debounced level Y and registered one-cycle RISE/FALL strobes.
module gf180mcu_osu_sc_gp12t3v3__rx_sync_filt #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CYCLES = 4,
  parameter int   CNT_W       = 8,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic CLK,
  input  logic RN,
  input  logic A,
  input  logic EN,
  output logic Y,
  output logic RISE,
  output logic FALL,
  output logic BUSY
);

  typedef enum logic {
    IDLE = 1'b0,
    QUAL = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s_sync;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   y_reg, y_next;
  logic                   rise_reg, rise_next;
  logic                   fall_reg, fall_next;
  logic                   mismatch;

  // Plain flop chain: nothing may sit between stages.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync_reg <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], A};
    end
  end

  assign s_sync   = sync_reg[SYNC_STAGES-1];
  assign mismatch = (s_sync != y_reg);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      y_reg     <= RST_VAL;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      y_reg     <= y_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    y_next     = y_reg;

    // Disable dominates, including on the edge that would have qualified.
    if (!EN) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_next = '0;
          if (mismatch) begin
            if (FILT_CYCLES == 1) begin
              y_next = s_sync;
            end else begin
              state_next = QUAL;
              cnt_next   = CNT_ONE;
            end
          end
        end
        QUAL: begin
          if (!mismatch) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cnt_reg == CNT_LAST) begin
            y_next     = s_sync;
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    rise_next = y_next & ~y_reg;
    fall_next = ~y_next & y_reg;
  end

  assign Y    = y_reg;
  assign RISE = rise_reg;
  assign FALL = fall_reg;
  assign BUSY = (state_reg == QUAL);

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__rx_sync_filt.sv
// Bench for the rx sync/filter: two instances (FILT_CYCLES 4 and 1) checked
// against a run-length reference model plus directed latency expectations.
module tb_gf180mcu_osu_sc_gp12t3v3__rx_sync_filt;

  localparam int SYNC = 2;

  logic CLK = 1'b0;
  logic RN  = 1'b0;
  logic A   = 1'b0;
  logic EN  = 1'b0;

  logic y0, rise0, fall0, busy0;
  logic y1, rise1, fall1, busy1;
  logic [3:0] v0, v1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  gf180mcu_osu_sc_gp12t3v3__rx_sync_filt #(
    .SYNC_STAGES(SYNC), .FILT_CYCLES(4), .CNT_W(8), .RST_VAL(1'b0)
  ) dut_f4 (
    .CLK(CLK), .RN(RN), .A(A), .EN(EN),
    .Y(y0), .RISE(rise0), .FALL(fall0), .BUSY(busy0)
  );

  gf180mcu_osu_sc_gp12t3v3__rx_sync_filt #(
    .SYNC_STAGES(SYNC), .FILT_CYCLES(1), .CNT_W(8), .RST_VAL(1'b0)
  ) dut_f1 (
    .CLK(CLK), .RN(RN), .A(A), .EN(EN),
    .Y(y1), .RISE(rise1), .FALL(fall1), .BUSY(busy1)
  );

  assign v0 = {y0, rise0, fall0, busy0};
  assign v1 = {y1, rise1, fall1, busy1};

  // Reference model: delayed copy of A, then a run-length count of enabled
  // cycles in which the delayed level differs from the accepted level.
  int   filt [2] = '{4, 1};
  logic m_s  [SYNC];
  logic m_y  [2];
  logic m_rise [2];
  logic m_fall [2];
  int   m_run  [2];

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_s[i] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_y[k] = 1'b0; m_rise[k] = 1'b0; m_fall[k] = 1'b0; m_run[k] = 0;
    end
  endtask

  task automatic model_edge();
    logic s;
    if (!RN) begin
      model_reset();
      return;
    end
    s = m_s[SYNC-1];
    for (int k = 0; k < 2; k++) begin
      m_rise[k] = 1'b0;
      m_fall[k] = 1'b0;
      if (!EN || s == m_y[k]) begin
        m_run[k] = 0;
      end else begin
        m_run[k]++;
        if (m_run[k] >= filt[k]) begin
          m_y[k]    = s;
          m_rise[k] = s;
          m_fall[k] = ~s;
          m_run[k]  = 0;
        end
      end
    end
    for (int i = SYNC - 1; i > 0; i--) m_s[i] = m_s[i-1];
    m_s[0] = A;
  endtask

  function automatic logic [3:0] exp_vec(input int k);
    return {m_y[k], m_rise[k], m_fall[k], (m_run[k] > 0)};
  endfunction

  // Drive inputs just after an edge, advance one edge, sample 1 time unit later.
  task automatic step(input logic a, input logic en);
    A  = a;
    EN = en;
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    RN = 1'b0; A = 1'b1; EN = 1'b1;
    model_reset();
    #2;
    n_total++;
    if (v0 !== 4'b0000) $display("FAIL reset_async_f4: got %b want 0000", v0); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b1);
      n_total++;
      if (v0 !== 4'b0000) $display("FAIL reset_hold_f4 c%0d: got %b want 0000", c, v0); else n_pass++;
      n_total++;
      if (v1 !== 4'b0000) $display("FAIL reset_hold_f1 c%0d: got %b want 0000", c, v1); else n_pass++;
    end
    #2 RN = 1'b1;
    step(1'b1, 1'b1);
    n_total++;
    if (v0 !== 4'b0000) $display("FAIL reset_release_f4: got %b want 0000", v0); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b1);
      n_total++;
      if (v0 !== exp_vec(0)) $display("FAIL reset_settle_f4 c%0d: got %b want %b", c, v0, exp_vec(0)); else n_pass++;
      n_total++;
      if (v1 !== exp_vec(1)) $display("FAIL reset_settle_f1 c%0d: got %b want %b", c, v1, exp_vec(1)); else n_pass++;
    end
    $display("test_reset done: %0d/%0d", n_pass, n_total);
  endtask

  task automatic test_latency();
    logic [3:0] want0, want1;
    for (int e = 1; e <= 9; e++) begin
      step(1'b1, 1'b1);
      want0 = {(e >= 6), (e == 6), 1'b0, (e >= 3 && e <= 5)};
      want1 = {(e >= 3), (e == 3), 1'b0, 1'b0};
      n_total++;
      if (v0 !== want0) $display("FAIL latency_f4 edge%0d: got %b want %b", e, v0, want0); else n_pass++;
      n_total++;
      if (v1 !== want1) $display("FAIL latency_f1 edge%0d: got %b want %b", e, v1, want1); else n_pass++;
    end
    $display("test_latency done: %0d/%0d", n_pass, n_total);
  endtask

  task automatic test_fall();
    logic [3:0] want0;
    for (int e = 1; e <= 10; e++) begin
      step(1'b0, 1'b1);
      want0 = {(e < 6), 1'b0, (e == 6), (e >= 3 && e <= 5)};
      n_total++;
      if (v0 !== want0) $display("FAIL fall_f4 edge%0d: got %b want %b", e, v0, want0); else n_pass++;
      n_total++;
      if (v1 !== exp_vec(1)) $display("FAIL fall_f1 edge%0d: got %b want %b", e, v1, exp_vec(1)); else n_pass++;
    end
    $display("test_fall done: %0d/%0d", n_pass, n_total);
  endtask

  task automatic test_glitch();
    for (int e = 1; e <= 10; e++) begin
      step((e <= 3), 1'b1);
      n_total++;
      if (y0 !== 1'b0 || rise0 !== 1'b0)
        $display("FAIL glitch_f4 edge%0d: got y=%b rise=%b want y=0 rise=0", e, y0, rise0);
      else n_pass++;
      n_total++;
      if (v0 !== exp_vec(0)) $display("FAIL glitch_model_f4 edge%0d: got %b want %b", e, v0, exp_vec(0)); else n_pass++;
      n_total++;
      if (v1 !== exp_vec(1)) $display("FAIL glitch_model_f1 edge%0d: got %b want %b", e, v1, exp_vec(1)); else n_pass++;
    end
    n_total++;
    if (busy0 !== 1'b0) $display("FAIL glitch_busy_drop: got %b want 0", busy0); else n_pass++;
    $display("test_glitch done: %0d/%0d", n_pass, n_total);
  endtask

  task automatic test_en_gating();
    for (int e = 1; e <= 3; e++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    n_total++;
    if (v0 !== 4'b0000) $display("FAIL en_drop_f4: got %b want 0000", v0); else n_pass++;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    n_total++;
    if (y0 !== 1'b0) $display("FAIL en_hold_f4: got y=%b want 0", y0); else n_pass++;
    for (int e = 1; e <= 6; e++) begin
      step(1'b1, 1'b1);
      n_total++;
      if (y0 !== (e >= 4)) $display("FAIL en_resume_f4 edge%0d: got y=%b want %b", e, y0, (e >= 4)); else n_pass++;
      n_total++;
      if (v0 !== exp_vec(0)) $display("FAIL en_model_f4 edge%0d: got %b want %b", e, v0, exp_vec(0)); else n_pass++;
      n_total++;
      if (v1 !== exp_vec(1)) $display("FAIL en_model_f1 edge%0d: got %b want %b", e, v1, exp_vec(1)); else n_pass++;
    end
    $display("test_en_gating done: %0d/%0d", n_pass, n_total);
  endtask

  task automatic test_midop_reset();
    for (int e = 1; e <= 4; e++) step(1'b0, 1'b1);
    n_total++;
    if (busy0 !== 1'b1) $display("FAIL midrst_qual_f4: got busy=%b want 1", busy0); else n_pass++;
    #2 RN = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (v0 !== 4'b0000) $display("FAIL midrst_async_f4: got %b want 0000", v0); else n_pass++;
    step(1'b0, 1'b1);
    #2 RN = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 1'b1);
      n_total++;
      if (v0 !== 4'b0000) $display("FAIL midrst_after_f4 edge%0d: got %b want 0000", e, v0); else n_pass++;
      n_total++;
      if (v1 !== 4'b0000) $display("FAIL midrst_after_f1 edge%0d: got %b want 0000", e, v1); else n_pass++;
    end
    $display("test_midop_reset done: %0d/%0d", n_pass, n_total);
  endtask

  task automatic test_random();
    int   len;
    logic a;
    logic en;
    a = 1'b0;
    for (int r = 0; r < 150; r++) begin
      a   = ~a;
      len = $urandom_range(1, 7);
      for (int c = 0; c < len; c++) begin
        en = ($urandom_range(0, 9) != 0);
        step(a, en);
        n_total++;
        if (v0 !== exp_vec(0)) $display("FAIL random_f4 r%0d c%0d: got %b want %b", r, c, v0, exp_vec(0)); else n_pass++;
        n_total++;
        if (v1 !== exp_vec(1)) $display("FAIL random_f1 r%0d c%0d: got %b want %b", r, c, v1, exp_vec(1)); else n_pass++;
        if ($urandom_range(0, 99) == 0) begin
          #2 RN = 1'b0;
          model_reset();
          #1;
          n_total++;
          if (v0 !== 4'b0000) $display("FAIL random_rst_f4 r%0d: got %b want 0000", r, v0); else n_pass++;
          #1 RN = 1'b1;
        end
      end
    end
    $display("test_random done: %0d/%0d", n_pass, n_total);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fall();
    test_glitch();
    test_en_gating();
    test_midop_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
